// File: rtl/lmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lmul_pkg
// Description : Shared FP16 field widths, constants and the FSM state type for
//               the logarithmic-multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lmul_pkg;

    localparam int FP16_SIGN_W = 1;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MAN_W  = 10;
    localparam int FP16_W      = FP16_SIGN_W + FP16_EXP_W + FP16_MAN_W;

    // Quiet NaN returned when the core never answers.
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lmul_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches req starting at
//               ptr, wrapping modulo N, and returns a one-hot grant plus its
//               encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    localparam logic [IDW:0] NV = (IDW+1)'(N);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    // First asserted request at or after ptr wins; the offset wraps past N-1.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lmul_arbiter
// Description : Shares one start/done FP16 log-multiplier core among NREQ
//               requesters. Round-robin grant, one job in flight, timeout
//               abort with qNaN result, tagged response with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module lmul_arbiter
    import lmul_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 16,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FP16_W-1:0] req_a,
    input  logic [NREQ*FP16_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   mul_start,
    output logic [FP16_W-1:0]      mul_a,
    output logic [FP16_W-1:0]      mul_b,
    input  logic                   mul_done,
    input  logic [FP16_W-1:0]      mul_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [FP16_W-1:0]      rsp_result,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam logic [7:0]     TMO     = 8'(TIMEOUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] job_id;
    logic [7:0]     cnt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;

    logic [FP16_W-1:0] op_a [NREQ];
    logic [FP16_W-1:0] op_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*FP16_W +: FP16_W];
        assign op_b[g] = req_b[g*FP16_W +: FP16_W];
    end

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Next-state logic; req_ready exposes the arbiter grant only while idle.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            ST_IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (mul_done || (cnt == TMO)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: latch the job, pulse start, count, capture result or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            job_id     <= '0;
            cnt        <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            busy      <= (next_state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        mul_a     <= op_a[gnt_id];
                        mul_b     <= op_b[gnt_id];
                        job_id    <= gnt_id;
                        mul_start <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 8'd1;
                end
                ST_WAIT: begin
                    cnt <= cnt + 8'd1;
                    // A done pulse on the final counter value still counts.
                    if (mul_done) begin
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                        rsp_id     <= job_id;
                        rsp_valid  <= 1'b1;
                    end else if (cnt == TMO) begin
                        rsp_result <= FP16_QNAN;
                        rsp_err    <= 1'b1;
                        rsp_id     <= job_id;
                        rsp_valid  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (job_id == LAST_ID) ? '0 : job_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lmul_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lmul_arbiter
// Description : Scoreboard bench for lmul_arbiter with a latency-programmable
//               core stub and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lmul_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              mul_start;
    logic [15:0]       mul_a;
    logic [15:0]       mul_b;
    logic              mul_done;
    logic [15:0]       mul_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_result;
    logic              rsp_err;
    logic              busy;

    always #5 clk = ~clk;

    lmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state (transaction level)
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
        int          rise;
    } job_t;

    job_t        exp_q[$];
    int          lat_q[$];
    int          grant_log[$];
    int          cyc       = 0;
    bit          inflight  = 0;
    int          mptr      = 0;
    int          exp_start = -1;
    int          last_id   = 0;
    logic [15:0] last_res  = '0;
    logic        last_err  = 1'b0;
    int          rsp_count = 0;
    int          force_lat = -2;   // -2: random, -1: core never answers

    // Log-domain product of two FP16 values: add biased encodings, drop one bias.
    function automatic logic [15:0] lmul(input logic [15:0] a, input logic [15:0] b);
        return a + b - 16'h3C00;
    endfunction

    // Monitor: predicts grant, timing and response contents; pops on handshake.
    always @(negedge clk) begin
        logic [NREQ-1:0] pg;
        int   gid;
        int   idx;
        int   lat;
        int   r;
        bit   evalid;
        job_t j;
        cyc++;
        if (rst) begin
            exp_q.delete();
            lat_q.delete();
            inflight  = 0;
            mptr      = 0;
            exp_start = -1;
            last_id   = 0;
            last_res  = '0;
            last_err  = 1'b0;
        end else begin
            pg  = '0;
            gid = -1;
            if (!inflight) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (gid < 0 && req_valid[idx]) begin
                        gid     = idx;
                        pg[idx] = 1'b1;
                    end
                end
            end
            check("req_ready", req_ready, pg);
            check("busy", busy, inflight);
            check("mul_start", mul_start, cyc == exp_start);
            evalid = (exp_q.size() > 0) && (cyc >= exp_q[0].rise);
            check("rsp_valid", rsp_valid, evalid);
            if (exp_q.size() > 0 && exp_start >= 0 && cyc >= exp_start && cyc < exp_q[0].rise) begin
                check("mul_a", mul_a, exp_q[0].a);
                check("mul_b", mul_b, exp_q[0].b);
            end
            if (evalid) begin
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_result", rsp_result, exp_q[0].res);
                check("rsp_err", rsp_err, exp_q[0].err);
                if (rsp_ready) begin
                    last_id  = exp_q[0].id;
                    last_res = exp_q[0].res;
                    last_err = exp_q[0].err;
                    mptr     = (exp_q[0].id + 1) % NREQ;
                    inflight = 0;
                    void'(exp_q.pop_front());
                    rsp_count++;
                end
            end else begin
                check("hold_id", rsp_id, last_id);
                check("hold_result", rsp_result, last_res);
                check("hold_err", rsp_err, last_err);
            end
            if (gid >= 0) begin
                if (force_lat != -2) begin
                    lat = force_lat;
                end else begin
                    r = int'($urandom_range(0, 9));
                    if (r == 0)      lat = -1;
                    else if (r == 1) lat = TIMEOUT;
                    else if (r == 2) lat = TIMEOUT + 1;
                    else             lat = int'($urandom_range(1, TIMEOUT - 1));
                end
                j.id   = gid;
                j.a    = req_a[gid*16 +: 16];
                j.b    = req_b[gid*16 +: 16];
                j.err  = (lat < 0) || (lat > TIMEOUT);
                j.res  = j.err ? 16'h7E00 : lmul(j.a, j.b);
                j.rise = cyc + 2 + (j.err ? TIMEOUT : lat);
                exp_q.push_back(j);
                lat_q.push_back(lat);
                grant_log.push_back(gid);
                inflight  = 1;
                exp_start = cyc + 1;
            end
        end
    end

    // Core stub: on start, answer after the queued latency (or never).
    initial begin
        int sc;
        int l;
        logic [15:0] sa;
        logic [15:0] sb;
        sc = -1;
        sa = '0;
        sb = '0;
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done   = 1'b0;
            mul_result = 16'($urandom);
            if (mul_start) begin
                sa = mul_a;
                sb = mul_b;
                if (lat_q.size() > 0) begin
                    l  = lat_q.pop_front();
                    sc = (l < 0) ? -1 : l;
                end else begin
                    sc = -1;
                end
            end else if (sc > 0) begin
                sc--;
                if (sc == 0) begin
                    mul_done   = 1'b1;
                    mul_result = lmul(sa, sb);
                    sc         = -1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [NREQ-1:0] v;
    logic [15:0]     va [NREQ];
    logic [15:0]     vb [NREQ];
    bit              reload    = 0;
    bit              auto_rand = 0;
    bit              rdy_rand  = 0;
    logic            rdy;

    task automatic newops(input int i);
        va[i] = 16'($urandom);
        vb[i] = 16'($urandom);
    endtask

    task automatic drive();
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*16 +: 16] = va[i];
            req_b[i*16 +: 16] = vb[i];
        end
        rsp_ready = rdy;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (reload) newops(i);
                else        v[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (auto_rand) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 3) == 0) begin
                    v[i] = 1'b1;
                    newops(i);
                end
            end
        end
        if (rdy_rand) rdy = ($urandom_range(0, 2) != 0);
        drive();
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        for (int n = 0; n < budget && rsp_count < target; n++) step();
        check(name, rsp_count >= target, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int n = 0; n < budget && (busy || rsp_valid); n++) step();
        check(name, {busy, rsp_valid}, 2'b00);
    endtask

    task automatic chk_reset();
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_id", rsp_id, 0);
    endtask

    initial begin
        int base;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        v   = '0;
        rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) step();

        // Single job: 2.0 * 3.0 from requester 2 with L = 7.
        force_lat = 7;
        v[2]  = 1'b1;
        va[2] = 16'h4000;
        vb[2] = 16'h4200;
        drive();
        wait_rsp(1, 40, "single_done");
        repeat (2) step();
        check("single_result", rsp_result, 16'h4600);
        check("single_id", rsp_id, 2);
        check("single_err", rsp_err, 0);

        // Contention: everyone valid out of reset.
        rst = 1'b1;
        v = '1;
        reload = 1;
        for (int i = 0; i < NREQ; i++) newops(i);
        force_lat = 3;
        drive();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = grant_log.size();
        wait_rsp(rsp_count + 5, 100, "contention_done");
        v = '0;
        reload = 0;
        drive();
        wait_idle(40, "contention_idle");
        for (int k = 0; k < 5; k++) begin
            check("grant_order", (grant_log.size() > base + k) ? grant_log[base + k] : -1, exp_order[k]);
        end

        // Backpressure: hold rsp_ready low for 10 cycles with others waiting.
        force_lat = 4;
        rdy    = 1'b0;
        reload = 1;
        v[1] = 1'b1; newops(1);
        v[3] = 1'b1; newops(3);
        drive();
        for (int n = 0; n < 40 && !rsp_valid; n++) step();
        check("bp_rsp_valid", rsp_valid, 1);
        repeat (10) step();
        rdy = 1'b1;
        drive();
        wait_rsp(rsp_count + 2, 60, "bp_done");
        v = '0;
        reload = 0;
        drive();
        wait_idle(40, "bp_idle");

        // Timeout: core never answers.
        force_lat = -1;
        v[0] = 1'b1; newops(0);
        drive();
        wait_rsp(rsp_count + 1, 60, "tmo_done");
        step();
        check("tmo_result", rsp_result, 16'h7E00);
        check("tmo_err", rsp_err, 1);

        // Late done pulse lands after the abort and must be ignored.
        force_lat = TIMEOUT + 2;
        v[2] = 1'b1; newops(2);
        drive();
        wait_rsp(rsp_count + 1, 60, "late_done");
        repeat (10) step();
        check("late_busy", busy, 0);
        check("late_rsp_valid", rsp_valid, 0);
        check("late_result", rsp_result, 16'h7E00);
        check("late_err", rsp_err, 1);

        // Boundary: done exactly when the counter reaches TIMEOUT.
        force_lat = TIMEOUT;
        v[1]  = 1'b1;
        va[1] = 16'h3C00;
        vb[1] = 16'h4400;
        drive();
        wait_rsp(rsp_count + 1, 60, "edge_done");
        step();
        check("edge_result", rsp_result, 16'h4400);
        check("edge_err", rsp_err, 0);

        // Reset mid-WAIT: ptr sits at 3 before the aborted job.
        force_lat = 5;
        v[2] = 1'b1; newops(2);
        drive();
        wait_rsp(rsp_count + 1, 40, "pre_rst_done");
        force_lat = 10;
        v[3] = 1'b1; newops(3);
        drive();
        for (int n = 0; n < 10 && !busy; n++) step();
        repeat (4) step();
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset();
        v[1] = 1'b1; newops(1);
        v[3] = 1'b1; newops(3);
        drive();
        @(posedge clk);
        #3;
        rst  = 1'b0;
        base = grant_log.size();
        wait_rsp(rsp_count + 1, 60, "post_rst_done");
        check("post_rst_grant", (grant_log.size() > base) ? grant_log[base] : -1, 1);
        wait_idle(60, "post_rst_idle");

        // Randomized traffic with random latencies and backpressure.
        force_lat = -2;
        auto_rand = 1;
        rdy_rand  = 1;
        base = rsp_count;
        repeat (3000) step();
        auto_rand = 0;
        rdy_rand  = 0;
        rdy = 1'b1;
        v   = '0;
        drive();
        wait_idle(200, "rand_idle");
        check("rand_progress", rsp_count > base + 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
